// File: rtl/ysyx_24100027_imm_pkg.sv
// Shared definitions for the immediate stage: format codes and the stored entry layout.
// RVC formats are decoded only when RV_IMM_RVC_EN is defined (selector widens to 4 bits).
package ysyx_24100027_imm_pkg;

`ifdef RV_IMM_RVC_EN
    localparam int IMM_EXTOP_W = 4;
`else
    localparam int IMM_EXTOP_W = 3;
`endif

    // Codes are kept 4 bits wide; the 3-bit build compares against the low bits.
    localparam logic [3:0] IMM_I   = 4'b0000;
    localparam logic [3:0] IMM_U   = 4'b0001;
    localparam logic [3:0] IMM_S   = 4'b0010;
    localparam logic [3:0] IMM_B   = 4'b0011;
    localparam logic [3:0] IMM_J   = 4'b0100;
    localparam logic [3:0] IMM_Z   = 4'b0101;
    localparam logic [3:0] IMM_SH  = 4'b0110;
    localparam logic [3:0] IMM_CI  = 4'b1000;
    localparam logic [3:0] IMM_CB  = 4'b1001;
    localparam logic [3:0] IMM_CJ  = 4'b1010;
    localparam logic [3:0] IMM_CIW = 4'b1011;

    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 64;

    // Sized for the widest configuration; the top narrows fields to XLEN/TAG_W.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/ysyx_24100027_imm_decode.sv
// Combinational instruction/format-selector to immediate decoder.
// RV_IMM_RVC_EN adds the compressed CI/CB/CJ/CIW formats.
module ysyx_24100027_imm_decode
    import ysyx_24100027_imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int EXTOP_W = IMM_EXTOP_W
) (
    input  logic [31:0]         inst,
    input  logic [EXTOP_W-1:0]  extop,
    output logic [XLEN-1:0]     imm,
    output logic                illegal
);

    logic [3:0]  code;
    logic [63:0] imm64;
    logic        unused_bits;

    assign code = 4'(extop);

    // Everything is built 64 bits wide and then cut to XLEN, so U-type only
    // gains real sign bits in the 64-bit build.
    always_comb begin
        imm64   = '0;
        illegal = 1'b0;
        case (code)
            IMM_I:   imm64 = {{52{inst[31]}}, inst[31:20]};
            IMM_U:   imm64 = {{32{inst[31]}}, inst[31:12], 12'h000};
            IMM_S:   imm64 = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm64 = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:   imm64 = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:   imm64 = {59'd0, inst[19:15]};
            IMM_SH:  imm64 = (XLEN == 64) ? {58'd0, inst[25:20]} : {59'd0, inst[24:20]};
`ifdef RV_IMM_RVC_EN
            IMM_CI:  imm64 = {{58{inst[12]}}, inst[12], inst[6:2]};
            IMM_CB:  imm64 = {{55{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10],
                              inst[4:3], 1'b0};
            IMM_CJ:  imm64 = {{52{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                              inst[2], inst[11], inst[5:3], 1'b0};
            IMM_CIW: imm64 = {54'd0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
`endif
            default: begin
                imm64   = '0;
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = imm64[XLEN-1:0];

`ifdef RV_IMM_RVC_EN
    assign unused_bits = ^imm64;
`else
    // Opcode bits carry no immediate in any 32-bit format.
    assign unused_bits = ^{imm64, inst[6:0]};
`endif

endmodule

// File: rtl/ysyx_24100027_imm_stage.sv
// Registered immediate-generation stage with an output register plus one skid entry.
// Optional RVC decoding is enabled by defining RV_IMM_RVC_EN.
module ysyx_24100027_imm_stage
    import ysyx_24100027_imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 32,   // at most TAG_MAX_W
    parameter int EXTOP_W = IMM_EXTOP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [EXTOP_W-1:0]  in_extop,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_imm,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_illegal
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    imm_entry_t      in_entry;
    imm_entry_t      out_reg;
    imm_entry_t      skid_reg;
    logic            out_valid_reg;
    logic            skid_valid_reg;
    logic            accept;
    logic            drain;
    logic            unused_bits;

    ysyx_24100027_imm_decode #(
        .XLEN    (XLEN),
        .EXTOP_W (EXTOP_W)
    ) u_decode (
        .inst    (in_inst),
        .extop   (in_extop),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    always_comb begin
        in_entry         = '0;
        in_entry.imm     = IMM_MAX_W'(dec_imm);
        in_entry.tag     = TAG_MAX_W'(in_tag);
        in_entry.illegal = dec_illegal;
    end

    assign accept = in_valid && !skid_valid_reg;
    assign drain  = out_valid_reg && out_ready;

    // accept and drain never coincide with a full skid, since in_ready is low then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (drain) begin
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_reg        <= in_entry;
            end else begin
                out_valid_reg  <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_reg) begin
                out_reg        <= in_entry;
                out_valid_reg  <= 1'b1;
            end else begin
                skid_reg       <= in_entry;
                skid_valid_reg <= 1'b1;
            end
        end
    end

    assign in_ready    = !skid_valid_reg;
    assign out_valid   = out_valid_reg;
    assign out_imm     = out_reg.imm[XLEN-1:0];
    assign out_tag     = out_reg.tag[TAG_W-1:0];
    assign out_illegal = out_reg.illegal;
    assign unused_bits = ^{out_reg, skid_reg};

endmodule

// File: tb/tb_ysyx_24100027_imm_stage.sv
// Directed bench: a 32-bit and a 64-bit stage share the same stimulus; each is checked
// against hand-computed immediates, handshake timing, back-pressure and async reset.
module tb_ysyx_24100027_imm_stage;
    import ysyx_24100027_imm_pkg::*;

    localparam int EW = IMM_EXTOP_W;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [31:0]   in_inst;
    logic [EW-1:0] in_extop;
    logic [31:0]   in_tag;
    logic          out_ready;

    logic          in_ready_32, out_valid_32, out_illegal_32;
    logic [31:0]   out_imm_32, out_tag_32;
    logic          in_ready_64, out_valid_64, out_illegal_64;
    logic [63:0]   out_imm_64;
    logic [31:0]   out_tag_64;

    int checks   = 0;
    int failures = 0;

    ysyx_24100027_imm_stage #(.XLEN(32), .TAG_W(32), .EXTOP_W(EW)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_32),
        .in_inst(in_inst), .in_extop(in_extop), .in_tag(in_tag),
        .out_valid(out_valid_32), .out_ready(out_ready),
        .out_imm(out_imm_32), .out_tag(out_tag_32), .out_illegal(out_illegal_32)
    );

    ysyx_24100027_imm_stage #(.XLEN(64), .TAG_W(32), .EXTOP_W(EW)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready_64),
        .in_inst(in_inst), .in_extop(in_extop), .in_tag(in_tag),
        .out_valid(out_valid_64), .out_ready(out_ready),
        .out_imm(out_imm_64), .out_tag(out_tag_64), .out_illegal(out_illegal_64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Accept one entry with out_ready=1, check it one cycle later, then let it drain.
    task automatic send_one(input string name, input logic [31:0] inst, input logic [3:0] op,
                            input logic [31:0] tag, input logic [31:0] e32,
                            input logic [63:0] e64, input logic eill);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = inst;
        in_extop  = EW'(op);
        in_tag    = tag;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_valid32"}, 64'(out_valid_32), 64'd1);
        check({name, "_valid64"}, 64'(out_valid_64), 64'd1);
        check({name, "_imm32"}, 64'(out_imm_32), 64'(e32));
        check({name, "_imm64"}, out_imm_64, e64);
        check({name, "_ill32"}, 64'(out_illegal_32), 64'(eill));
        check({name, "_ill64"}, 64'(out_illegal_64), 64'(eill));
        check({name, "_tag"}, 64'(out_tag_64), 64'(tag));
        $display("txn %s inst=%h op=%h imm32=%h imm64=%h ill=%0b", name, inst, op,
                 out_imm_32, out_imm_64, out_illegal_64);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_extop  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", 64'(out_valid_32), 64'd0);
        check("rst_ready", 64'(in_ready_32), 64'd1);
        check("rst_imm64", out_imm_64, 64'd0);
        check("rst_tag", 64'(out_tag_32), 64'd0);
        check("rst_ill", 64'(out_illegal_64), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_one("I_m1",   32'hFFF00093, IMM_I,  32'h10, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_one("U_neg",  32'h800000B7, IMM_U,  32'h11, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send_one("S_m8",   32'hFE000C23, IMM_S,  32'h12, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
        send_one("B_m4096",32'h80000063, IMM_B,  32'h13, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0);
        send_one("B_2046", 32'h7E000F63, IMM_B,  32'h14, 32'h000007FE, 64'h00000000000007FE, 1'b0);
        send_one("J_m1M",  32'h8000006F, IMM_J,  32'h15, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0);
        send_one("J_2046", 32'h7FE0006F, IMM_J,  32'h16, 32'h000007FE, 64'h00000000000007FE, 1'b0);
        send_one("Z_31",   32'h800F8073, IMM_Z,  32'h17, 32'h0000001F, 64'h000000000000001F, 1'b0);
        send_one("SH_max", 32'h83F01013, IMM_SH, 32'h18, 32'h0000001F, 64'h000000000000003F, 1'b0);
        send_one("RSV",    32'hFFFFFFFF, 4'b0111, 32'h19, 32'h00000000, 64'h0, 1'b1);
`ifdef RV_IMM_RVC_EN
        send_one("CI_m1",  32'h00001FFD, IMM_CI, 32'h1A, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
`endif

        // Back-pressure: tags 1,2,3 with out_ready held low.
        @(negedge clk);
        check("drained", 64'(out_valid_64), 64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_extop  = EW'(IMM_I);
        in_inst   = 32'h00100093;
        in_tag    = 32'd1;
        @(negedge clk);
        check("bp_ready_after1", 64'(in_ready_32), 64'd1);
        in_tag = 32'd2;
        @(negedge clk);
        check("bp_ready_after2", 64'(in_ready_64), 64'd0);
        in_tag = 32'd3;
        @(negedge clk);
        check("bp_hold_tag", 64'(out_tag_32), 64'd1);
        check("bp_hold_imm", 64'(out_imm_32), 64'd1);
        check("bp_ready_held", 64'(in_ready_32), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_out2_tag", 64'(out_tag_64), 64'd2);
        check("bp_out2_valid", 64'(out_valid_64), 64'd1);
        check("bp_ready_free", 64'(in_ready_64), 64'd1);
        $display("txn bp out tag=%0d", out_tag_64);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out3_tag", 64'(out_tag_32), 64'd3);
        check("bp_out3_valid", 64'(out_valid_32), 64'd1);
        $display("txn bp out tag=%0d", out_tag_32);
        @(negedge clk);
        check("bp_empty", 64'(out_valid_32), 64'd0);

        // Fill both entries, then assert reset between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 32'd5;
        @(negedge clk);
        in_tag = 32'd6;
        @(negedge clk);
        in_valid = 1'b0;
        check("full_ready", 64'(in_ready_32), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid32", 64'(out_valid_32), 64'd0);
        check("arst_valid64", 64'(out_valid_64), 64'd0);
        check("arst_ready", 64'(in_ready_64), 64'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", 64'(out_valid_64), 64'd0);
        check("post_rst_tag", 64'(out_tag_32), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_24100027_imm_stage.md
# ysyx_24100027_imm_stage

Parametrised, pipelined immediate generator for the NPC decode path. It accepts a 32-bit instruction word, a format selector and a sideband tag over a valid/ready handshake. It produces the sign- or zero-extended XLEN-wide immediate one cycle later, also over a valid/ready handshake. A two-entry skid buffer decouples fetch/decode back-pressure from EXU stalls, so the block can sit as a registered stage between IFU and IDU without a combinational ready path.

## Interface
- XLEN, 32, immediate width; legal values 32 or 64
- TAG_W, 32, width of the sideband tag carried with each instruction (typically the PC)
- EXTOP_W, 3, format selector width; must be 4 when RVC_EN is defined
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept; registered, equals "skid entry empty"
- in_inst  input  32  instruction word (compressed forms in bits [15:0])
- in_extop  input  EXTOP_W  format selector
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  immediate valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  generated immediate
- out_tag  output  TAG_W  tag matching out_imm
- out_illegal  output  1  selector was a reserved code; out_imm is 0

## Operation
- Format codes use sext to XLEN and zext to XLEN:
  - 000 I: sext inst[31:20]
  - 001 U: sext {inst[31:12], 12'h0}; sign-extension is meaningful only for XLEN=64
  - 010 S: sext {inst[31:25], inst[11:7]}
  - 011 B: sext {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - 100 J: sext {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - 101 Z (CSR zimm): zext inst[19:15]
  - 110 SH (shamt): zext inst[25:20] when XLEN=64, zext inst[24:20] when XLEN=32
  - 111: reserved; imm=0, illegal=1
- Immediate computation is combinational on the input side. The result, the tag and the illegal flag are captured together as one entry.
- Storage is a main output register plus one skid entry.
- Accept when in_valid && in_ready:
  - If the output register is empty, or is draining this cycle (out_valid && out_ready), the entry goes to the output register.
  - Otherwise the entry goes to the skid register.
- On drain with the skid entry full, the skid entry moves to the output register and the skid entry clears.
- Entries are never reordered, dropped or duplicated.

## Timing
- Latency: an entry accepted in cycle N is presented in cycle N+1 when the stage was empty.
- Throughput: one entry per cycle while out_ready=1.
- in_ready is a register output: it is 1 iff the skid entry is empty, with no combinational path from out_ready.
- Simultaneous accept and drain with the skid entry full cannot occur, because in_ready=0.
- Simultaneous accept and drain with the output register full and skid empty: the new entry replaces the output register and the skid entry stays empty.
- out_imm, out_tag and out_illegal hold stable while out_valid && !out_ready.
- Reset (asynchronous assert, synchronous-style release on clk):
  - out_valid=0, out_imm=0, out_tag=0, out_illegal=0
  - skid entry empty, so in_ready=1 immediately after reset
- Reset mid-operation discards both entries.

## Configuration
- RV_IMM_RVC_EN: when defined, EXTOP_W=4 and the 1xxx codes decode C-extension formats from inst[15:0]:
  - 1000 CI: sext {inst[12], inst[6:2]}
  - 1001 CB: sext {inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 0}
  - 1010 CJ: sext {inst[12], inst[8], inst[10:9], inst[6], inst[7], inst[2], inst[11], inst[5:3], 0}
  - 1011 CIW: zext {inst[10:7], inst[12:11], inst[5], inst[6], 00}
  - Remaining 1xxx codes: illegal.
- When not defined: EXTOP_W=3 and there is no RVC decode logic.

## Structure
- Shared package ysyx_24100027_imm_pkg holds:
  - the format-code localparams (IMM_I, IMM_U, IMM_S, IMM_B, IMM_J, IMM_Z, IMM_SH, plus the RVC codes)
  - a packed entry struct {imm, tag, illegal}
- One sub-module: ysyx_24100027_imm_decode, the purely combinational inst/extop to {imm, illegal} function. The top module holds only the skid/output registers and the handshake.

## Test plan
- XLEN=32, inst=32'hFFF00093, extop=I → out_imm=32'hFFFFFFFF one cycle after accept, illegal=0.
- XLEN=64, inst=32'h800000B7, extop=U → out_imm=64'hFFFFFFFF80000000.
- B and J encodings for offsets −4096 and +2046 and for −1048576 round-trip to the expected values.
- Back-pressure: hold out_ready=0, stream three entries with tags 1, 2, 3:
  - in_ready drops after tag 2 is accepted; tag 3 waits.
  - Release out_ready: outputs arrive in order 1, 2, 3 with no gaps.
- extop=111 → out_imm=0, out_illegal=1. With RV_IMM_RVC_EN, inst[15:0]=16'h1FFD and extop=CI → imm=−1.
- Assert rst_n=0 with both entries full → out_valid=0 and in_ready=1 asynchronously. No stale entry appears after release.
